// File: rtl/otter_csr_unit.sv
// -----------------------------------------------------------------------------
// otter_csr_unit
// Machine-mode CSR file and trap sequencer for the pipelined Otter, located in
// the execute stage. Executes Zicsr read-modify-write operations, returns the
// old CSR value for register write-back, takes external interrupts and mret
// returns, and hands fetch a redirect target plus flush request.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   ex_valid            execute-stage instruction is real (not bubble/squashed)
//   csr_en, mret        decoder strobes
//   funct3, csr_addr    CSR operation select and address (instr[31:20])
//   rs1_data, zimm      register / immediate source operands
//   ex_pc               PC of the execute-stage instruction
//   intr                asynchronous level-sensitive external interrupt
//   csr_rdata           old value of the addressed CSR (combinational)
//   redirect            flush pipeline and fetch from redirect_pc
//   redirect_pc         redirect target
//   int_taken           current redirect is an interrupt entry
// -----------------------------------------------------------------------------
module otter_csr_unit #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ex_valid,
    input  logic        csr_en,
    input  logic        mret,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic [31:0] ex_pc,
    input  logic        intr,
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        int_taken
);
    // A zero-cycle flush still needs a legal (unused) counter width.
    localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, meip_q;
    logic          mie_q, mie_d;       // mstatus.MIE
    logic          mpie_q, mpie_d;     // mstatus.MPIE
    logic          meie_q, meie_d;     // mie.MEIE
    logic [31:0]   mtvec_q, mtvec_d;
    logic [31:0]   mscratch_q, mscratch_d;
    logic [31:0]   mepc_q, mepc_d;
    logic [31:0]   mcause_q, mcause_d;

    logic          run;
    logic          int_take;
    logic          mret_take;
    logic [31:0]   src;
    logic [31:0]   wdata;
    logic          wr_req;
    logic          csr_we;

    // Old-value read mux.
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            A_MIE:      csr_rdata = {20'h0, meie_q, 11'h0};
            A_MTVEC:    csr_rdata = mtvec_q;
            A_MSCRATCH: csr_rdata = mscratch_q;
            A_MEPC:     csr_rdata = mepc_q;
            A_MCAUSE:   csr_rdata = mcause_q;
            A_MIP:      csr_rdata = {20'h0, meip_q, 11'h0};
            default:    csr_rdata = 32'h0;
        endcase
    end

    // Operation decode. RS/RC with a zero source must not write at all.
    always_comb begin
        src    = funct3[2] ? {27'h0, zimm} : rs1_data;
        wdata  = 32'h0;
        wr_req = 1'b0;
        case (funct3[1:0])
            2'b01: begin wdata = src;               wr_req = 1'b1;          end
            2'b10: begin wdata = csr_rdata | src;   wr_req = (src != 32'h0); end
            2'b11: begin wdata = csr_rdata & ~src;  wr_req = (src != 32'h0); end
            default: begin wdata = 32'h0;           wr_req = 1'b0;          end
        endcase
    end

    // Trap arbitration: interrupt > mret > CSR write.
    assign run         = (state_q == RUN);
    assign int_take    = run && ex_valid && mie_q && meie_q && meip_q;
    assign mret_take   = run && ex_valid && mret && !int_take;
    assign csr_we      = run && ex_valid && csr_en && !int_take && !mret_take && wr_req;
    assign redirect    = int_take || mret_take;
    assign int_taken   = int_take;
    assign redirect_pc = int_take ? mtvec_q : mepc_q;

    // Next-state for FSM and CSR file.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        if (csr_we) begin
            case (csr_addr)
                A_MSTATUS:  begin mie_d = wdata[3]; mpie_d = wdata[7]; end
                A_MIE:      meie_d     = wdata[11];
                A_MTVEC:    mtvec_d    = {wdata[31:2], 2'b00};
                A_MSCRATCH: mscratch_d = wdata;
                A_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = wdata;
                default:    ;
            endcase
        end

        if (int_take) begin
            mepc_d   = {ex_pc[31:2], 2'b00};
            mcause_d = 32'h8000_000B;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_take) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (redirect && (FLUSH_CYCLES > 0)) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                // Counter was loaded with FLUSH_CYCLES-1, so leaving at zero
                // yields exactly FLUSH_CYCLES cycles here.
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            sync1_q    <= 1'b0;
            meip_q     <= 1'b0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= intr;
            meip_q     <= sync1_q;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

endmodule

// File: tb/tb_otter_csr_unit.sv
module tb_otter_csr_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, csr_en, mret, intr;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data, ex_pc;
    logic [4:0]  zimm;
    logic [31:0] csr_rdata, redirect_pc;
    logic        redirect, int_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    otter_csr_unit #(.FLUSH_CYCLES(2), .MTVEC_RESET(32'h0000_0000)) dut (
        .CLK(clk), .RST_N(rst_n), .ex_valid(ex_valid), .csr_en(csr_en),
        .mret(mret), .funct3(funct3), .csr_addr(csr_addr), .rs1_data(rs1_data),
        .zimm(zimm), .ex_pc(ex_pc), .intr(intr), .csr_rdata(csr_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .int_taken(int_taken)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
            $display("check %-16s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic redir_check(input string tag, input logic r, input logic it, input logic [31:0] pc);
        push({tag, "_redir"}, {31'h0, r});
        push({tag, "_int"}, {31'h0, it});
        observe({31'h0, redirect});
        observe({31'h0, int_taken});
        if (r) begin
            push({tag, "_pc"}, pc);
            observe(redirect_pc);
        end
    endtask

    task automatic idle();
        ex_valid = 1'b0; csr_en = 1'b0; mret = 1'b0;
        funct3 = 3'b000; csr_addr = 12'h000; rs1_data = 32'h0; zimm = 5'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One CSR instruction in execute for one cycle; immediate forms get a
    // conflicting rs1_data so the source select is exercised.
    task automatic csr_op(input string tag, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] s, input logic [31:0] exp_old);
        ex_valid = 1'b1; csr_en = 1'b1; funct3 = f3; csr_addr = a;
        if (f3[2]) begin zimm = s[4:0]; rs1_data = 32'hFFFF_FFFF; end
        else       begin zimm = 5'h1F;  rs1_data = s;            end
        push(tag, exp_old);
        @(negedge clk);
        observe(csr_rdata);
        cyc();
        idle();
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] v);
        csr_op(tag, 3'b010, a, 32'h0, v);
    endtask

    initial begin
        idle();
        intr = 1'b0; ex_pc = 32'h0; rst_n = 1'b0;
        #12 rst_n = 1'b1;
        cyc();

        // Reset state
        @(negedge clk);
        redir_check("reset", 1'b0, 1'b0, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);

        // mtvec low bits forced, RS with x0 does not write
        csr_op("rw_mtvec", 3'b001, 12'h305, 32'h0000_1003, 32'h0);
        rd("mtvec_rs_x0", 12'h305, 32'h0000_1000);
        rd("mtvec_again", 12'h305, 32'h0000_1000);

        // mstatus set/clear immediate
        csr_op("rsi_mstatus", 3'b110, 12'h300, 32'h8, 32'h0);
        csr_op("rci_mstatus", 3'b111, 12'h300, 32'h8, 32'h8);
        rd("mstatus_clr", 12'h300, 32'h0);

        // mip read-only, unimplemented address, mscratch RC
        csr_op("rw_mip", 3'b001, 12'h344, 32'hFFFF_FFFF, 32'h0);
        rd("mip_ro", 12'h344, 32'h0);
        csr_op("rw_unimpl", 3'b001, 12'h7C0, 32'h1234_5678, 32'h0);
        rd("unimpl_zero", 12'h7C0, 32'h0);
        csr_op("rw_mscr", 3'b001, 12'h340, 32'hF0F0_FFFF, 32'h0);
        csr_op("rc_mscr", 3'b011, 12'h340, 32'h0000_00FF, 32'hF0F0_FFFF);
        rd("mscr_rc", 12'h340, 32'hF0F0_FF00);

        // Enable interrupts
        csr_op("rw_mie", 3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0);
        rd("mie_meie", 12'h304, 32'h0000_0800);
        csr_op("rsi_mie_bit", 3'b110, 12'h300, 32'h8, 32'h0);

        // Interrupt: intr rises, taken on 3rd edge
        ex_valid = 1'b1; ex_pc = 32'h0000_0200; intr = 1'b1;
        @(negedge clk);
        redir_check("int_e0", 1'b0, 1'b0, 32'h0);
        cyc();
        @(negedge clk);
        redir_check("int_e1", 1'b0, 1'b0, 32'h0);
        cyc();
        @(negedge clk);
        redir_check("int_e2", 1'b1, 1'b1, 32'h0000_1000);
        cyc();
        // FLUSH: mret strobes must be ignored for exactly 2 cycles
        intr = 1'b0; ex_valid = 1'b1; mret = 1'b1;
        @(negedge clk);
        redir_check("flush1", 1'b0, 1'b0, 32'h0);
        cyc();
        @(negedge clk);
        redir_check("flush2", 1'b0, 1'b0, 32'h0);
        cyc();
        idle();
        csr_op("rw_mscr_run", 3'b001, 12'h340, 32'h0000_0055, 32'hF0F0_FF00);
        rd("mscr_after_fl", 12'h340, 32'h0000_0055);
        rd("mepc_trap", 12'h341, 32'h0000_0200);
        rd("mcause_trap", 12'h342, 32'h8000_000B);
        rd("mstatus_trap", 12'h300, 32'h0000_0080);

        // mret
        ex_valid = 1'b1; mret = 1'b1;
        @(negedge clk);
        redir_check("mret", 1'b1, 1'b0, 32'h0000_0200);
        cyc();
        idle();
        cyc();
        cyc();
        rd("mstatus_mret", 12'h300, 32'h0000_0088);

        // Interrupt pending alongside CSRRW mscratch
        intr = 1'b1;
        cyc();
        cyc();
        ex_valid = 1'b1; csr_en = 1'b1; funct3 = 3'b001; csr_addr = 12'h340;
        rs1_data = 32'hDEAD_BEEF; ex_pc = 32'h0000_0340;
        @(negedge clk);
        redir_check("int_vs_csr", 1'b1, 1'b1, 32'h0000_1000);
        push("int_csr_rdata", 32'h0000_0055);
        observe(csr_rdata);
        cyc();
        idle();
        intr = 1'b0;
        cyc();
        cyc();
        rd("mscr_kept", 12'h340, 32'h0000_0055);
        rd("mepc_trap2", 12'h341, 32'h0000_0340);
        rd("mstatus_trap2", 12'h300, 32'h0000_0080);

        // Reset during FLUSH
        ex_valid = 1'b1; mret = 1'b1;
        @(negedge clk);
        redir_check("mret2", 1'b1, 1'b0, 32'h0000_0340);
        cyc();
        idle();
        #2 rst_n = 1'b0;
        #1;
        csr_addr = 12'h300;
        #1;
        redir_check("in_reset", 1'b0, 1'b0, 32'h0);
        push("rst_mstatus2", 32'h0);
        observe(csr_rdata);
        csr_addr = 12'h341;
        #1;
        push("rst_mepc2", 32'h0);
        observe(csr_rdata);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        csr_op("rw_after_rst", 3'b001, 12'h340, 32'h0000_0077, 32'h0);
        rd("mscr_after_rst", 12'h340, 32'h0000_0077);
        rd("mtvec_after_rst", 12'h305, 32'h0);
        rd("mcause_after_rst", 12'h342, 32'h0);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
